soc_otg_hpi_bridge: RTL and testbench
=====================================

// Module: soc_otg_hpi_bridge
// PURPOSE
//   Avalon-MM slave that executes one CY7C67200 HPI bus cycle per Avalon access.
//   The Nios II addresses one of the four HPI registers and gets a 16-bit read or write on
//   the OTG chip pins. Strobe setup, width and hold are generated internally.
//   The block stalls the master with waitrequest until the HPI cycle has completed.
//   It replaces the per-signal address, data, read and write PIO ports with a single timed transaction engine.
//   Top level owns the tri-state buffer on OTG_DATA: drive otg_data_out when otg_data_oe=1.
// PARAMETERS
//   SETUP_CYC   2   clk cycles with cs_n low and addr/data stable before the strobe (>=1)
//   STROBE_CYC  4   clk cycles with rd_n/wr_n held low (>=1)
//   HOLD_CYC    2   clk cycles with cs_n low and addr/data held after the strobe (>=1)
// PORTS
//   clk            in   1   system clock; single clock domain
//   reset_n        in   1   asynchronous, active-low reset
//   address        in   2   HPI register select: 0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS
//   chipselect     in   1   Avalon slave select
//   read_n         in   1   Avalon read, active low
//   write_n        in   1   Avalon write, active low
//   writedata      in   32  write data; only bits [15:0] are used
//   readdata       out  32  {16'b0, captured HPI data}; registered
//   waitrequest    out  1   high while a request is held and not yet complete
//   otg_addr       out  2   HPI address pins
//   otg_data_out   out  16  data driven to HPI during writes
//   otg_data_oe    out  1   tri-state enable for otg_data_out
//   otg_data_in    in   16  data sampled from HPI pins
//   otg_cs_n       out  1   HPI chip select, active low
//   otg_rd_n       out  1   HPI read strobe, active low
//   otg_wr_n       out  1   HPI write strobe, active low
// BEHAVIOUR
//   Request: req = chipselect & (~read_n | ~write_n). If read_n and write_n are both low, the access is a write.
//   States: IDLE, SETUP, STROBE, HOLD, DONE. One down-counter of width clog2(max param)+1.
//   IDLE: on req, latch address, writedata[15:0] and direction; load counter=SETUP_CYC; go to SETUP.
//   SETUP: cs_n=0, addr valid, oe=1 if write; count down to 0, then load STROBE_CYC and go to STROBE.
//   STROBE: rd_n=0 (read) or wr_n=0 (write); on the last STROBE cycle, register otg_data_in into readdata[15:0]
//     for reads; load HOLD_CYC and go to HOLD.
//   HOLD: strobes are high, cs_n=0, addr and data/oe are unchanged; count down to 0, then go to DONE.
//   DONE: cs_n=1, oe=0, waitrequest=0 for exactly 1 cycle, so the master retires the access; next state is IDLE.
//   waitrequest is combinational: waitrequest = req & (state != DONE). It is high in IDLE on the cycle req first appears.
//   Latency: waitrequest is high for 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles, then low for 1 cycle.
//     With default parameters that is 9 cycles high and 1 low.
//   Back-to-back: a request presented in the cycle after DONE starts from IDLE. There is always >=1 clk with cs_n=1 between cycles.
//   Strobe, cs_n, addr and data are registered outputs, so no glitches. addr, data and oe do not change while cs_n=0.
//   chipselect dropping mid-cycle is a protocol violation: the HPI cycle still runs through DONE, then the block goes to IDLE.
//   readdata holds its last captured value until the next read. Writes never alter readdata.
//   Reset (async, any state): state=IDLE, otg_cs_n=1, otg_rd_n=1, otg_wr_n=1, otg_data_oe=0, otg_addr=0,
//     otg_data_out=0, readdata=0, counter=0. The strobes release on the reset edge with no wait for clk.
// TESTING
//   1 Write addr=2 data=0x1234: cs_n low 8 clks; wr_n low clks 3-6 of cs_n; otg_addr=2; data_out=0x1234
//     with oe=1 throughout; waitrequest high 9, low 1.
//   2 Read addr=0 with otg_data_in=0xBEEF during strobe: rd_n low 4 clks, oe=0; readdata=0x0000BEEF in the DONE
//     cycle and held after.
//   3 Back-to-back write then read with no idle from the master: cs_n is high for >=1 clk between cycles; each
//     access completes in 10 clks.
//   4 reset_n low midway through STROBE: wr_n, cs_n and oe return high/0 asynchronously, readdata=0;
//     the next request starts cleanly from IDLE.
//   5 SETUP_CYC=STROBE_CYC=HOLD_CYC=1: cs_n low 3 clks, strobe low 1 clk, waitrequest high 4 clks then low 1.
//   6 read_n=0 and write_n=0 together, writedata=0xA5A5: a write cycle occurs with wr_n low and rd_n high, and
//     readdata is unchanged.

Source files
------------

// File: rtl/soc_otg_hpi_bridge.sv
// ---------------------------------------------------------------------------
// soc_otg_hpi_bridge
//   Avalon-MM slave that turns each Avalon access into one timed CY7C67200 HPI
//   bus cycle (setup / strobe / hold). The master is stalled with waitrequest
//   until the HPI cycle has finished. The tri-state buffer on OTG_DATA is
//   owned by the top level: it drives otg_data_out while otg_data_oe=1.
//
// Ports
//   clk, reset_n       system clock, asynchronous active-low reset
//   address[1:0]       HPI register select (0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS)
//   chipselect         Avalon slave select
//   read_n, write_n    Avalon strobes, active low (both low = write)
//   writedata[31:0]    write data, bits [15:0] used
//   readdata[31:0]     {16'b0, last captured HPI data}, registered
//   waitrequest        high while a request is held and not yet complete
//   otg_addr[1:0]      HPI address pins
//   otg_data_out[15:0] data driven to HPI during writes
//   otg_data_oe        tri-state enable for otg_data_out
//   otg_data_in[15:0]  data sampled from the HPI pins
//   otg_cs_n           HPI chip select, active low
//   otg_rd_n, otg_wr_n HPI strobes, active low
// ---------------------------------------------------------------------------
module soc_otg_hpi_bridge #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n
);

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_SH > STROBE_CYC) ? MAX_SH : STROBE_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          is_wr, is_wr_nxt;
  logic          capture;
  logic          req, req_wr;
  logic [15:0]   rdata_q;

  logic          cs_n_nxt, rd_n_nxt, wr_n_nxt, oe_nxt;
  logic [1:0]    addr_nxt;
  logic [15:0]   dout_nxt;

  // Upper write-data bits have no destination on a 16-bit HPI bus.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^writedata[31:16];

  assign req         = chipselect & (~read_n | ~write_n);
  assign req_wr      = ~write_n;  // write wins when both strobes are low
  assign waitrequest = req & (state != DONE);
  assign readdata    = {16'b0, rdata_q};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      is_wr <= is_wr_nxt;
    end
  end

  // Next-state logic. The counter is loaded with the phase length and the
  // phase ends on the cycle it reads 1, so each phase lasts exactly N cycles.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    is_wr_nxt = is_wr;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SETUP;
          cnt_nxt   = CW'(SETUP_CYC);
          is_wr_nxt = req_wr;
        end
      end
      SETUP: begin
        if (cnt == CW'(1)) begin
          state_nxt = STROBE;
          cnt_nxt   = CW'(STROBE_CYC);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (cnt == CW'(1)) begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(HOLD_CYC);
          capture   = ~is_wr;  // sample read data at the end of the strobe
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic, computed from the next state so the pins can be registered
  // and stay glitch-free. Address and data are captured once, when leaving
  // IDLE, and held untouched for the whole cs_n-low window.
  always_comb begin
    cs_n_nxt = 1'b1;
    rd_n_nxt = 1'b1;
    wr_n_nxt = 1'b1;
    oe_nxt   = 1'b0;
    addr_nxt = otg_addr;
    dout_nxt = otg_data_out;
    if (state == IDLE && req) begin
      addr_nxt = address;
      if (req_wr) dout_nxt = writedata[15:0];
    end
    unique case (state_nxt)
      SETUP, HOLD: begin
        cs_n_nxt = 1'b0;
        oe_nxt   = is_wr_nxt;
      end
      STROBE: begin
        cs_n_nxt = 1'b0;
        oe_nxt   = is_wr_nxt;
        rd_n_nxt = is_wr_nxt;
        wr_n_nxt = ~is_wr_nxt;
      end
      default: ;
    endcase
  end

  // Pin registers; reset releases the strobes immediately, without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_data_oe  <= 1'b0;
      otg_addr     <= '0;
      otg_data_out <= '0;
      rdata_q      <= '0;
    end else begin
      otg_cs_n     <= cs_n_nxt;
      otg_rd_n     <= rd_n_nxt;
      otg_wr_n     <= wr_n_nxt;
      otg_data_oe  <= oe_nxt;
      otg_addr     <= addr_nxt;
      otg_data_out <= dout_nxt;
      if (capture) rdata_q <= otg_data_in;
    end
  end

endmodule

// File: tb/tb_soc_otg_hpi_bridge.sv
`timescale 1ns/1ps
module tb_soc_otg_hpi_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel;  // 0: default-timing DUT, 1: minimal-timing DUT
  logic        cs, rdn, wrn;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [15:0] otg_data_in;

  logic [31:0] rd0, rd1;
  logic        wait0, wait1, oe0, oe1, csn0, csn1, rdn0, rdn1, wrn0, wrn1;
  logic [1:0]  addr0, addr1;
  logic [15:0] dout0, dout1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  soc_otg_hpi_bridge dut0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs & ~sel), .read_n(rdn | sel), .write_n(wrn | sel),
    .writedata(writedata), .readdata(rd0), .waitrequest(wait0),
    .otg_addr(addr0), .otg_data_out(dout0), .otg_data_oe(oe0),
    .otg_data_in(otg_data_in), .otg_cs_n(csn0), .otg_rd_n(rdn0), .otg_wr_n(wrn0)
  );

  soc_otg_hpi_bridge #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs & sel), .read_n(rdn | ~sel), .write_n(wrn | ~sel),
    .writedata(writedata), .readdata(rd1), .waitrequest(wait1),
    .otg_addr(addr1), .otg_data_out(dout1), .otg_data_oe(oe1),
    .otg_data_in(otg_data_in), .otg_cs_n(csn1), .otg_rd_n(rdn1), .otg_wr_n(wrn1)
  );

  // Monitor view of whichever DUT is selected.
  logic [31:0] m_rd;
  logic        m_wait, m_oe, m_csn, m_rdn, m_wrn;
  logic [1:0]  m_addr;
  logic [15:0] m_dout;
  assign m_rd   = sel ? rd1   : rd0;
  assign m_wait = sel ? wait1 : wait0;
  assign m_oe   = sel ? oe1   : oe0;
  assign m_csn  = sel ? csn1  : csn0;
  assign m_rdn  = sel ? rdn1  : rdn0;
  assign m_wrn  = sel ? wrn1  : wrn0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_dout = sel ? dout1 : dout0;

  typedef struct {
    logic        wr;
    logic        both;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [15:0] exp_rd;
    int          exp_wait;
    int          exp_cs;
    int          exp_stb;
    int          exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    cs  = 1'b0;
    rdn = 1'b1;
    wrn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request (entered at posedge+1) and watch the selected DUT
  // until waitrequest drops. Returns at posedge+1 with the request still held.
  task automatic access(input logic wr, input logic both, input logic [1:0] a,
                        input logic [15:0] wd, input logic [15:0] din,
                        output int wait_hi, output int cs_lo, output int stb_lo,
                        output int stb_first, output int cs_hi_pre, output int viol,
                        output logic [31:0] rd_done, output logic timed_out);
    logic seen_lo, stb, other;
    address     = a;
    writedata   = {16'hDEAD, wd};
    otg_data_in = din;
    cs  = 1'b1;
    wrn = wr ? 1'b0 : 1'b1;
    rdn = (!wr || both) ? 1'b0 : 1'b1;
    wait_hi = 0; cs_lo = 0; stb_lo = 0; stb_first = 0; cs_hi_pre = 0; viol = 0;
    rd_done = '0; timed_out = 1'b1; seen_lo = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_wait) wait_hi++;
      if (!m_csn) begin
        seen_lo = 1'b1;
        cs_lo++;
        if (m_oe !== wr || m_addr !== a || (wr && m_dout !== wd)) viol++;
        stb   = wr ? m_wrn : m_rdn;
        other = wr ? m_rdn : m_wrn;
        if (!stb) begin
          stb_lo++;
          if (stb_first == 0) stb_first = cs_lo;
        end
        if (!other) viol++;
      end else begin
        if (!seen_lo) cs_hi_pre++;
        if (!m_rdn || !m_wrn || m_oe) viol++;
      end
      if (!m_wait) begin
        rd_done   = m_rd;
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          w_hi, c_lo, s_lo, s_first, c_pre, v;
  logic [31:0] rdv;
  logic        tmo;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           wr    both  addr  wdata     din       exp_rd    wait cs stb first
    vecs[0] = '{1'b1, 1'b0, 2'd2, 16'h1234, 16'h0000, 16'h0000, 9, 8, 4, 3};
    vecs[1] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 16'hBEEF, 9, 8, 4, 3};
    vecs[2] = '{1'b1, 1'b0, 2'd1, 16'h5555, 16'h0000, 16'hBEEF, 9, 8, 4, 3};
    vecs[3] = '{1'b0, 1'b0, 2'd3, 16'h0000, 16'h0F0F, 16'h0F0F, 9, 8, 4, 3};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 16'hA5A5, 16'h1111, 16'h0F0F, 9, 8, 4, 3};
    vecs[5] = '{1'b0, 1'b0, 2'd1, 16'h0000, 16'hFFFF, 16'hFFFF, 9, 8, 4, 3};

    sel = 1'b0; cs = 1'b0; rdn = 1'b1; wrn = 1'b1;
    address = '0; writedata = '0; otg_data_in = '0;
    reset_n = 1'b0;

    // Reset state.
    #22;
    check("rst cs_n", csn0, 1);
    check("rst rd_n", rdn0, 1);
    check("rst wr_n", wrn0, 1);
    check("rst oe", oe0, 0);
    check("rst addr", addr0, 0);
    check("rst data_out", dout0, 0);
    check("rst readdata", rd0, 0);
    check("rst waitrequest", wait0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // Table-driven single accesses with default timing.
    for (int i = 0; i < 6; i++) begin
      access(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].wdata, vecs[i].din,
             w_hi, c_lo, s_lo, s_first, c_pre, v, rdv, tmo);
      idle(1);
      check($sformatf("v%0d timeout", i), tmo, 0);
      check($sformatf("v%0d wait cycles", i), w_hi, vecs[i].exp_wait);
      check($sformatf("v%0d cs_n low cycles", i), c_lo, vecs[i].exp_cs);
      check($sformatf("v%0d strobe low cycles", i), s_lo, vecs[i].exp_stb);
      check($sformatf("v%0d strobe start", i), s_first, vecs[i].exp_first);
      check($sformatf("v%0d pin violations", i), v, 0);
      check($sformatf("v%0d readdata at done", i), rdv, {16'h0, vecs[i].exp_rd});
      check($sformatf("v%0d readdata held", i), rd0, {16'h0, vecs[i].exp_rd});
    end

    // Back-to-back write then read with no idle from the master.
    access(1'b1, 1'b0, 2'd2, 16'h00C3, 16'h0000, w_hi, c_lo, s_lo, s_first, c_pre, v, rdv, tmo);
    check("b2b wr timeout", tmo, 0);
    check("b2b wr wait cycles", w_hi, 9);
    check("b2b wr violations", v, 0);
    access(1'b0, 1'b0, 2'd3, 16'h0000, 16'h7777, w_hi, c_lo, s_lo, s_first, c_pre, v, rdv, tmo);
    idle(1);
    check("b2b rd timeout", tmo, 0);
    check("b2b rd wait cycles", w_hi, 9);
    check("b2b cs_n gap", (c_pre >= 1) ? 1 : 0, 1);
    check("b2b rd cs_n low cycles", c_lo, 8);
    check("b2b rd readdata", rdv, 32'h0000_7777);

    // Reset asserted in the middle of a write strobe.
    address = 2'd1; writedata = 32'h0000_4321; cs = 1'b1; wrn = 1'b0; rdn = 1'b1;
    repeat (5) @(negedge clk);
    check("mid strobe wr_n low", wrn0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst wr_n", wrn0, 1);
    check("async rst cs_n", csn0, 1);
    check("async rst oe", oe0, 0);
    check("async rst readdata", rd0, 0);
    cs = 1'b0; wrn = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);
    access(1'b0, 1'b0, 2'd0, 16'h0000, 16'h2468, w_hi, c_lo, s_lo, s_first, c_pre, v, rdv, tmo);
    idle(1);
    check("post rst timeout", tmo, 0);
    check("post rst wait cycles", w_hi, 9);
    check("post rst strobe start", s_first, 3);
    check("post rst readdata", rdv, 32'h0000_2468);

    // Minimal timing variant.
    sel = 1'b1;
    idle(1);
    access(1'b1, 1'b0, 2'd1, 16'h00AA, 16'h0000, w_hi, c_lo, s_lo, s_first, c_pre, v, rdv, tmo);
    idle(1);
    check("min wr timeout", tmo, 0);
    check("min wr wait cycles", w_hi, 4);
    check("min wr cs_n low cycles", c_lo, 3);
    check("min wr strobe low cycles", s_lo, 1);
    check("min wr strobe start", s_first, 2);
    check("min wr violations", v, 0);
    access(1'b0, 1'b0, 2'd2, 16'h0000, 16'h1357, w_hi, c_lo, s_lo, s_first, c_pre, v, rdv, tmo);
    idle(1);
    check("min rd wait cycles", w_hi, 4);
    check("min rd strobe low cycles", s_lo, 1);
    check("min rd readdata", rdv, 32'h0000_1357);
    check("default dut untouched", rd0, 32'h0000_2468);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
